// File: rtl/jorgenkraghjakobsen_pipecleaner_if.sv
// Tiny-tapeout style I/O bundle for the pipecleaner bring-up block.
// The master side drives enable and inputs; the slave side drives the outputs.
interface jorgenkraghjakobsen_pipecleaner_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/jorgenkraghjakobsen_pipecleaner.sv
// Four parallel 8-bit bring-up engines (delay pipe, counter, LFSR, accumulator) muxed onto uo_out.
// Optional 4-bit output signature enabled by defining PIPECLEANER_SIGNATURE_EN.
module jorgenkraghjakobsen_pipecleaner #(
  parameter int DEPTH   = 4,
  parameter int HB_BITS = 8
) (
  input logic clk,
  input logic rst,
  jorgenkraghjakobsen_pipecleaner_if.slave io
);

  localparam int                FILL_W   = 4;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [7:0]         pipe [DEPTH];
  logic [FILL_W-1:0]  fill;
  logic [7:0]         cnt;
  logic [7:0]         lfsr;
  logic [7:0]         acc;
  logic               carry;
  logic [HB_BITS-1:0] hb_cnt;

  logic [1:0] mode;
  logic       hold;
  logic       flush;
  logic       adv;
  logic       valid;
  logic [7:0] sel;
  logic [3:0] sig_nib;
  logic       unused_uio;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [8:0] acc_add(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign mode       = io.uio_in[1:0];
  assign hold       = io.uio_in[2];
  assign flush      = io.uio_in[3];
  assign adv        = io.ena & ~hold;
  assign valid      = (fill == FILL_MAX);
  assign unused_uio = &{1'b0, io.uio_in[7:4]};

  // Delay pipeline: flush wins over advance, and both need ena
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= 8'h00;
      fill <= '0;
    end else if (io.ena && flush) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= 8'h00;
      fill <= '0;
    end else if (adv) begin
      pipe[0] <= io.ui_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  // Counter, LFSR and accumulator ignore flush
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 8'h00;
      lfsr  <= 8'h01;
      acc   <= 8'h00;
      carry <= 1'b0;
    end else if (adv) begin
      cnt          <= cnt + 8'h01;
      lfsr         <= lfsr_step(lfsr);
      {carry, acc} <= acc_add(acc, io.ui_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         hb_cnt <= '0;
    else if (io.ena) hb_cnt <= hb_cnt + 1'b1;
  end

  always_comb begin
    sel = 8'h00;
    case (mode)
      2'b00:   sel = pipe[DEPTH-1];
      2'b01:   sel = cnt;
      2'b10:   sel = lfsr;
      default: sel = acc;
    endcase
  end

`ifdef PIPECLEANER_SIGNATURE_EN
  logic [3:0] sig;

  // Signature folds the visible output value, so it depends on the selected mode
  always_ff @(posedge clk) begin
    if (rst)      sig <= 4'h0;
    else if (adv) sig <= sig ^ sel[7:4] ^ sel[3:0];
  end

  assign sig_nib   = sig;
  assign io.uio_oe = 8'hFF;
`else
  assign sig_nib   = 4'h0;
  assign io.uio_oe = 8'hF0;
`endif

  assign io.uo_out  = sel;
  assign io.uio_out = {^sel, carry, valid, hb_cnt[HB_BITS-1], sig_nib};

endmodule

// File: tb/tb_jorgenkraghjakobsen_pipecleaner.sv
// Randomized and directed bench for the pipecleaner, checked against a queue/arithmetic model.
module tb_jorgenkraghjakobsen_pipecleaner;
  localparam int DEPTH   = 4;
  localparam int HB_BITS = 8;

  logic clk;
  logic rst;
  jorgenkraghjakobsen_pipecleaner_if io();

  jorgenkraghjakobsen_pipecleaner #(.DEPTH(DEPTH), .HB_BITS(HB_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [7:0] m_pipe [$];
  int         m_fill;
  int         m_cnt;
  logic [7:0] m_lfsr;
  int         m_acc;
  int         m_carry;
  int         m_hb;
  int         m_sig;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back(8'h00);
    m_fill = 0; m_cnt = 0; m_lfsr = 8'h01; m_acc = 0; m_carry = 0; m_hb = 0; m_sig = 0;
  endtask

  function automatic logic [7:0] exp_uo(input logic [1:0] mode);
    case (mode)
      2'd0:    return m_pipe[0];
      2'd1:    return 8'(m_cnt);
      2'd2:    return m_lfsr;
      default: return 8'(m_acc);
    endcase
  endfunction

  function automatic logic [7:0] exp_uio(input logic [1:0] mode);
    logic [7:0] u;
    logic [7:0] r;
    u = exp_uo(mode);
    r = 8'h00;
    r[7] = ^u;
    r[6] = (m_carry != 0);
    r[5] = (m_fill == DEPTH);
    r[4] = ((m_hb >> (HB_BITS-1)) & 1) != 0;
`ifdef PIPECLEANER_SIGNATURE_EN
    r[3:0] = 4'(m_sig);
`endif
    return r;
  endfunction

  function automatic logic [7:0] exp_oe();
`ifdef PIPECLEANER_SIGNATURE_EN
    return 8'hFF;
`else
    return 8'hF0;
`endif
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    logic [7:0] u;
    int sum;
    if (r) begin
      model_reset();
      return;
    end
    if (!e) return;
    m_hb = (m_hb + 1) % (1 << HB_BITS);
    u = exp_uo(uio[1:0]);
    if (uio[3]) begin
      for (int i = 0; i < DEPTH; i++) m_pipe[i] = 8'h00;
      m_fill = 0;
    end else if (!uio[2]) begin
      m_pipe.push_back(ui);
      void'(m_pipe.pop_front());
      if (m_fill < DEPTH) m_fill++;
    end
    if (!uio[2]) begin
      m_sig   = m_sig ^ int'(u[7:4]) ^ int'(u[3:0]);
      m_cnt   = (m_cnt + 1) % 256;
      m_lfsr  = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
      sum     = m_acc + int'(ui);
      m_carry = (sum > 255) ? 1 : 0;
      m_acc   = sum % 256;
    end
  endtask

  // Apply inputs, compare outputs mid-cycle, then clock the DUT and the model together
  task automatic cycle(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    rst = r; io.ena = e; io.ui_in = ui; io.uio_in = uio;
    @(negedge clk);
    check("uo_out", {24'h0, io.uo_out}, {24'h0, exp_uo(uio[1:0])});
    check("uio_out", {24'h0, io.uio_out}, {24'h0, exp_uio(uio[1:0])});
    check("uio_oe", {24'h0, io.uio_oe}, {24'h0, exp_oe()});
    @(posedge clk);
    model_step(r, e, ui, uio);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    io.uio_in = {6'b0, m};
    #1;
  endtask

  logic [7:0] lfsr_tab [6];
  logic [7:0] saved_uo;
  logic [7:0] saved_uio;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    lfsr_tab = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    rst = 1'b1; io.ena = 1'b0; io.ui_in = 8'h00; io.uio_in = 8'h00;
    @(posedge clk);
    model_reset();
    #1;

    // Reset state across all modes
    set_mode(2'd0); check("rst_pipe", {24'h0, io.uo_out}, 32'h00);
    check("rst_uio_out", {24'h0, io.uio_out}, 32'h00);
    set_mode(2'd1); check("rst_cnt", {24'h0, io.uo_out}, 32'h00);
    set_mode(2'd2); check("rst_lfsr", {24'h0, io.uo_out}, 32'h01);
    set_mode(2'd3); check("rst_acc", {24'h0, io.uo_out}, 32'h00);

    // LFSR sequence
    cycle(1'b1, 1'b1, 8'h00, 8'h02);
    for (int i = 0; i < 6; i++) begin
      check("lfsr_seq", {24'h0, io.uo_out}, {24'h0, lfsr_tab[i]});
      if (i < 5) cycle(1'b0, 1'b1, 8'h00, 8'h02);
    end

    // Pipeline latency, valid and flush
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 8'hA5, 8'h00);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h00, 8'h00);
    check("pipe_early", {24'h0, io.uo_out}, 32'h00);
    check("valid_early", {31'h0, io.uio_out[5]}, 32'h0);
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    check("pipe_latency", {24'h0, io.uo_out}, 32'hA5);
    check("valid_full", {31'h0, io.uio_out[5]}, 32'h1);
    cycle(1'b0, 1'b1, 8'h00, 8'h0C);
    check("flush_pipe", {24'h0, io.uo_out}, 32'h00);
    check("flush_valid", {31'h0, io.uio_out[5]}, 32'h0);

    // Accumulator carry and parity
    cycle(1'b1, 1'b1, 8'h00, 8'h03);
    cycle(1'b0, 1'b1, 8'hF0, 8'h03);
    check("acc_f0", {24'h0, io.uo_out}, 32'hF0);
    check("carry_0", {31'h0, io.uio_out[6]}, 32'h0);
    cycle(1'b0, 1'b1, 8'h20, 8'h03);
    check("acc_10", {24'h0, io.uo_out}, 32'h10);
    check("carry_1", {31'h0, io.uio_out[6]}, 32'h1);
    check("parity_1", {31'h0, io.uio_out[7]}, 32'h1);

    // Counter wrap, hold, and ena freeze
    cycle(1'b1, 1'b1, 8'h00, 8'h01);
    for (int i = 0; i < 256; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'h01);
    check("cnt_wrap", {24'h0, io.uo_out}, 32'h00);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    saved_uo = io.uo_out;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h11, 8'h05);
    check("hold_cnt", {24'h0, io.uo_out}, {24'h0, saved_uo});
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    saved_uo  = io.uo_out;
    saved_uio = io.uio_out;
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b0, 8'($urandom), 8'h09);
    check("ena0_uo", {24'h0, io.uo_out}, {24'h0, saved_uo});
    check("ena0_uio", {24'h0, io.uio_out}, {24'h0, saved_uio});

    // Reset mid-run
    cycle(1'b1, 1'b1, 8'h00, 8'h03);
    cycle(1'b0, 1'b1, 8'h7F, 8'h03);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 8'h03);
    check("pre_rst_acc", {24'h0, io.uo_out}, 32'h7F);
    cycle(1'b1, 1'b1, 8'h55, 8'h03);
    check("mid_rst_acc", {24'h0, io.uo_out}, 32'h00);
    check("mid_rst_valid", {31'h0, io.uio_out[5]}, 32'h0);
    check("mid_rst_hb", {31'h0, io.uio_out[4]}, 32'h0);
    set_mode(2'd2);
    check("mid_rst_lfsr", {24'h0, io.uo_out}, 32'h01);

`ifdef PIPECLEANER_SIGNATURE_EN
    cycle(1'b1, 1'b1, 8'h00, 8'h01);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    check("sig_cnt3", {28'h0, io.uio_out[3:0]}, 32'h3);
    check("sig_oe", {24'h0, io.uio_oe}, 32'hFF);
`else
    check("oe_default", {24'h0, io.uio_oe}, 32'hF0);
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       e;
      logic [7:0] uio;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 7) != 0);
      uio = 8'($urandom);
      uio[2] = ($urandom_range(0, 3) == 0);
      uio[3] = ($urandom_range(0, 15) == 0);
      cycle(r, e, 8'($urandom), uio);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
